// File: rtl/stopwatch_bcd_ctrl.sv
// stopwatch_bcd_ctrl: 3-digit BCD stopwatch with start/stop, lap freeze and sticky overflow
module stopwatch_bcd_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       ss_btn,
  input  logic       lr_btn,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic       running,
  output logic       frozen,
  output logic       overflow
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  state_t        state_q, state_d;
  logic          ss_q, lr_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [11:0]   cnt_q, cnt_d, lat_q, lat_d, cnt_inc;
  logic          ovf_q, ovf_d, run_q, frz_q;
  logic          ss_ev, lr_ev, active, tick, clr, c0, c1, c2;

  always_comb begin
    ss_ev   = ss_btn & ~ss_q;
    lr_ev   = lr_btn & ~lr_q & ~ss_ev;
    active  = (state_q == RUN) || (state_q == LAP);
    tick    = active && (pre_q == PMAX);
    c0      = cnt_q[3:0] == 4'd9;
    c1      = c0 && (cnt_q[7:4] == 4'd9);
    c2      = c1 && (cnt_q[11:8] == 4'd9);
    cnt_inc = {c2 ? 4'd0 : c1 ? cnt_q[11:8] + 4'd1 : cnt_q[11:8],
               c1 ? 4'd0 : c0 ? cnt_q[7:4] + 4'd1 : cnt_q[7:4],
               c0 ? 4'd0 : cnt_q[3:0] + 4'd1};
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ss_ev ? RUN : IDLE;
      RUN:     state_d = ss_ev ? PAUSE : lr_ev ? LAP : RUN;
      LAP:     state_d = ss_ev ? PAUSE : lr_ev ? RUN : LAP;
      default: state_d = ss_ev ? RUN : lr_ev ? IDLE : PAUSE;
    endcase
    clr     = (state_q == PAUSE) && (state_d == IDLE);
    pre_d   = (clr || state_q == IDLE) ? '0 : tick ? '0 : active ? pre_q + PW'(1) : pre_q;
    cnt_d   = clr ? '0 : tick ? cnt_inc : cnt_q;
    ovf_d   = clr ? 1'b0 : (tick && c2) ? 1'b1 : ovf_q;
    lat_d   = (state_q == RUN && lr_ev) ? cnt_q : lat_q;
  end

  always_ff @(posedge clk) begin
    if (!aclr) begin
      state_q <= IDLE;
      ss_q    <= 1'b1;
      lr_q    <= 1'b1;
      pre_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
      frz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= ss_btn;
      lr_q    <= lr_btn;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      ovf_q   <= ovf_d;
      run_q   <= (state_d == RUN) || (state_d == LAP);
      frz_q   <= state_d == LAP;
    end
  end

  assign {dig2, dig1, dig0} = frz_q ? lat_q : cnt_q;
  assign running  = run_q;
  assign frozen   = frz_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_stopwatch_bcd_ctrl.sv
// tb_stopwatch_bcd_ctrl: vector table, corner sequences and random run against an integer model
module tb_stopwatch_bcd_ctrl;
  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic       clk = 1'b0, aclr = 1'b0, ss_btn = 1'b0, lr_btn = 1'b0;
  logic [3:0] dig0, dig1, dig2;
  logic       running, frozen, overflow;
  int         passed = 0, total = 0;
  int         m_state, m_cnt, m_lat, m_pre;
  bit         m_ovf, m_ssq, m_lrq;

  typedef struct {
    bit a, s, l;
    int n;
    int disp;
    bit r, f, o;
  } vec_t;
  vec_t tbl[19];

  always #5 clk = ~clk;

  stopwatch_bcd_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .aclr(aclr), .ss_btn(ss_btn), .lr_btn(lr_btn),
    .dig0(dig0), .dig1(dig1), .dig2(dig2),
    .running(running), .frozen(frozen), .overflow(overflow)
  );

  function automatic int shown();
    return int'(dig2) * 100 + int'(dig1) * 10 + int'(dig0);
  endfunction

  task automatic model_step(input bit a, input bit s, input bit l);
    bit sev, lev, act, tk;
    int old;
    if (!a) begin
      m_state = M_IDLE; m_cnt = 0; m_lat = 0; m_pre = 0; m_ovf = 0; m_ssq = 1; m_lrq = 1;
    end else begin
      sev = s && !m_ssq;
      lev = l && !m_lrq && !sev;
      act = (m_state == M_RUN) || (m_state == M_LAP);
      tk  = act && (m_pre == TD - 1);
      old = m_cnt;
      if (act) m_pre = (m_pre + 1) % TD;
      if (tk) begin
        if (m_cnt == 999) m_ovf = 1;
        m_cnt = (m_cnt + 1) % 1000;
      end
      case (m_state)
        M_IDLE:  if (sev) m_state = M_RUN;
        M_RUN:   if (sev) m_state = M_PAUSE; else if (lev) begin m_state = M_LAP; m_lat = old; end
        M_LAP:   if (sev) m_state = M_PAUSE; else if (lev) m_state = M_RUN;
        default: if (sev) m_state = M_RUN;
                 else if (lev) begin m_state = M_IDLE; m_cnt = 0; m_pre = 0; m_ovf = 0; end
      endcase
      m_ssq = s;
      m_lrq = l;
    end
  endtask

  task automatic cyc(input bit a, input bit s, input bit l);
    aclr = a; ss_btn = s; lr_btn = l;
    @(posedge clk);
    model_step(a, s, l);
    #1;
  endtask

  task automatic check_out(input string name, input int ed, input bit er, input bit ef, input bit eo);
    total++;
    if (shown() == ed && running == er && frozen == ef && overflow == eo) passed++;
    else $display("FAIL %s: got disp=%0d run/frz/ovf=%b%b%b expected disp=%0d run/frz/ovf=%b%b%b",
                  name, shown(), running, frozen, overflow, ed, er, ef, eo);
  endtask

  task automatic check_model(input string name);
    check_out(name, (m_state == M_LAP) ? m_lat : m_cnt,
              (m_state == M_RUN) || (m_state == M_LAP), m_state == M_LAP, m_ovf);
  endtask

  task automatic run_until(input int target, input int bound, input string name);
    int n = 0;
    while (shown() != target && n < bound) begin
      cyc(1, 0, 0);
      n++;
    end
    total++;
    if (shown() == target) passed++;
    else $display("FAIL %s: timeout, got disp=%0d expected %0d", name, shown(), target);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 2,  0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 1,  0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 1,  0, 1, 0, 0};
    tbl[3]  = '{1, 1, 0, 4,  1, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 8,  3, 1, 0, 0};
    tbl[5]  = '{1, 0, 1, 1,  3, 1, 1, 0};
    tbl[6]  = '{1, 0, 0, 7,  3, 1, 1, 0};
    tbl[7]  = '{1, 0, 1, 1,  5, 1, 0, 0};
    tbl[8]  = '{1, 1, 1, 1,  5, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 20, 5, 0, 0, 0};
    tbl[10] = '{1, 0, 1, 1,  0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 1,  0, 0, 0, 0};
    tbl[12] = '{1, 1, 0, 1,  0, 1, 0, 0};
    tbl[13] = '{1, 0, 0, 10, 2, 1, 0, 0};
    tbl[14] = '{1, 1, 1, 1,  2, 0, 0, 0};
    tbl[15] = '{1, 0, 0, 20, 2, 0, 0, 0};
    tbl[16] = '{1, 1, 0, 1,  2, 1, 0, 0};
    tbl[17] = '{1, 0, 0, 1,  3, 1, 0, 0};
    tbl[18] = '{0, 0, 0, 1,  0, 0, 0, 0};
    for (int i = 0; i < 19; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].a, tbl[i].s, tbl[i].l);
      check_out($sformatf("vec%0d", i), tbl[i].disp, tbl[i].r, tbl[i].f, tbl[i].o);
    end

    // wrap 999 -> 000 with sticky overflow, cleared only on IDLE entry
    cyc(0, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 0, 0);
    run_until(998, 5000, "reach998");
    repeat (4) cyc(1, 0, 0);
    check_out("wrap999", 999, 1, 0, 0);
    repeat (4) cyc(1, 0, 0);
    check_out("wrap000", 0, 1, 0, 1);
    repeat (4) cyc(1, 0, 0);
    check_out("ovf_sticky", 1, 1, 0, 1);
    cyc(1, 1, 0);
    check_out("pause_ovf", 1, 0, 0, 1);
    cyc(1, 0, 0); cyc(1, 0, 1);
    check_out("idle_clr", 0, 0, 0, 0);
    check_model("idle_model");

    // button held through reset release must not start the watch
    cyc(0, 1, 0); cyc(0, 1, 0);
    repeat (10) cyc(1, 1, 0);
    check_out("held_ss", 0, 0, 0, 0);
    cyc(1, 0, 0); cyc(1, 1, 0);
    check_out("press_after", 0, 1, 0, 0);
    cyc(1, 0, 0);

    // reset in LAP beats everything and clears the prescaler
    run_until(345, 2000, "reach345");
    cyc(1, 0, 1);
    check_out("lap345", 345, 1, 1, 0);
    repeat (6) cyc(1, 0, 0);
    check_out("lap_hold", 345, 1, 1, 0);
    cyc(0, 1, 1);
    check_out("rst_lap", 0, 0, 0, 0);
    cyc(1, 0, 0); cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);
    check_out("pre_cleared", 0, 1, 0, 0);
    cyc(1, 0, 0);
    check_out("first_tick", 1, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      bit a, s, l;
      a = $urandom_range(0, 299) != 0;
      s = ($urandom_range(0, 5) == 0) ? ~ss_btn : ss_btn;
      l = ($urandom_range(0, 5) == 0) ? ~lr_btn : lr_btn;
      cyc(a, s, l);
      check_model($sformatf("rand%0d", i));
      total++;
      if (dig0 <= 9 && dig1 <= 9 && dig2 <= 9) passed++;
      else $display("FAIL digit_range%0d: got %h%h%h expected all digits <= 9", i, dig2, dig1, dig0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
